// File: rtl/lfsr_pkg.sv
// Shared types, constants and helpers for the LFSR step controller.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_e;

  // Active-low segments: bit7=a ... bit1=g, bit0=dp (dp held off).
  function automatic logic [7:0] hex2seg(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0: s = 8'b0000_0011;
      4'h1: s = 8'b1001_1111;
      4'h2: s = 8'b0010_0101;
      4'h3: s = 8'b0000_1101;
      4'h4: s = 8'b1001_1001;
      4'h5: s = 8'b0100_1001;
      4'h6: s = 8'b0100_0001;
      4'h7: s = 8'b0001_1111;
      4'h8: s = 8'b0000_0001;
      4'h9: s = 8'b0000_1001;
      4'hA: s = 8'b0001_0001;
      4'hB: s = 8'b1100_0001;
      4'hC: s = 8'b0110_0011;
      4'hD: s = 8'b1000_0101;
      4'hE: s = 8'b0110_0001;
      default: s = 8'b0111_0001;
    endcase
    return s;
  endfunction

  // One Fibonacci step; the all-zero lock-up state is forced back to the seed.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    if (s == '0) n = LFSR_RESET;
    else         n = {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button to one-cycle command pulse: 2-FF synchroniser, stability
// down-counter, rising-edge detect on the accepted level.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          acc_dly_q;
  logic          pulse_q;

  // Timer runs only while the synchronised level differs from the accepted one.
  always_comb begin
    cnt_d = RELOAD;
    acc_d = acc_q;
    if (sync2_q != acc_q) begin
      if (cnt_q == '0) acc_d = sync2_q;
      else             cnt_d = cnt_q - CW'(1);
    end
  end

  // Synchroniser, debounce state and registered edge pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= RELOAD;
      acc_q     <= 1'b0;
      acc_dly_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      acc_dly_q <= acc_q;
      pulse_q   <= acc_q & ~acc_dly_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/lfsr_step_ctrl.sv
// LFSR step controller: three debounced buttons drive single-step, free-run
// and seed-load of an 8-bit Fibonacci LFSR shown on LEDs and two hex digits.
// Optional macro LFSR_STEP_CNT_EN keeps the shift counter; without it
// step_cnt reads 0.
//
// state | meaning
// IDLE  | waiting; step cmd shifts once
// RUN   | shifting once every TICK_DIV clocks
// LOAD  | one cycle: take seed from sw, clear counter
module lfsr_step_ctrl
  import lfsr_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int TICK_DIV     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_step,
  input  logic              btn_run,
  input  logic              btn_load,
  input  logic [LFSR_W-1:0] sw,
  output logic [LFSR_W-1:0] ledr,
  output logic [7:0]        seg0,
  output logic [7:0]        seg1,
  output logic              running,
  output logic [7:0]        step_cnt
);

  localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);

  logic step_cmd, run_cmd, load_cmd;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_step (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_step), .pulse_o(step_cmd)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_run (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_run), .pulse_o(run_cmd)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_load (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_load), .pulse_o(load_cmd)
  );

  state_e             state_q, state_d;
  logic [PSC_W-1:0]   psc_q, psc_d;
  logic [LFSR_W-1:0]  ledr_q, ledr_d;
  logic [7:0]         seg0_q, seg1_q;
  logic               shift;

  // Next state, prescaler and LFSR update; load beats run beats step.
  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    ledr_d  = ledr_q;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_cmd) begin
          state_d = LOAD;
        end else if (run_cmd) begin
          state_d = RUN;
          psc_d   = '0;
        end else if (step_cmd) begin
          shift = 1'b1;
        end
      end
      RUN: begin
        if (load_cmd) begin
          state_d = LOAD;
        end else if (run_cmd) begin
          state_d = IDLE;
        end else if (psc_q == PSC_LAST) begin
          shift = 1'b1;
          psc_d = '0;
        end else begin
          psc_d = psc_q + PSC_W'(1);
        end
      end
      LOAD: begin
        ledr_d  = (sw == '0) ? LFSR_RESET : sw;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (shift) ledr_d = lfsr_next(ledr_q);
  end

  // Control state and LFSR register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      psc_q   <= '0;
      ledr_q  <= LFSR_RESET;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      ledr_q  <= ledr_d;
    end
  end

  // Digits decode the current LFSR register, so they trail it by one clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg0_q <= hex2seg(LFSR_RESET[3:0]);
      seg1_q <= hex2seg(LFSR_RESET[7:4]);
    end else begin
      seg0_q <= hex2seg(ledr_q[3:0]);
      seg1_q <= hex2seg(ledr_q[7:4]);
    end
  end

`ifdef LFSR_STEP_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Shift counter, cleared by a seed load, wraps naturally at 256.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == LOAD) cnt_d = '0;
    else if (shift)      cnt_d = cnt_q + 8'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign step_cnt = cnt_q;
`else
  assign step_cnt = 8'h00;
`endif

  assign ledr    = ledr_q;
  assign seg0    = seg0_q;
  assign seg1    = seg1_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Directed bench for lfsr_step_ctrl (DEBOUNCE_CYC=16, TICK_DIV=4).
module tb_lfsr_step_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_step, btn_run, btn_load;
  logic [7:0] sw;
  logic [7:0] ledr, seg0, seg1, step_cnt;
  logic       running;

  lfsr_step_ctrl #(.DEBOUNCE_CYC(16), .TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .btn_run(btn_run),
    .btn_load(btn_load), .sw(sw), .ledr(ledr), .seg0(seg0), .seg1(seg1),
    .running(running), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

`ifdef LFSR_STEP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int nchg;
  bit saw_run;

  typedef struct {
    logic [2:0] btns;   // bit0 step, bit1 run, bit2 load
    logic [7:0] sw;
    logic [7:0] ledr;
    logic [7:0] seg1;
    logic [7:0] seg0;
    int         cnt;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [7:0] ecnt(input int n);
    return CNT_EN ? 8'(n) : 8'h00;
  endfunction

  function automatic logic [7:0] model_shift(input logic [7:0] s);
    if (s == 8'h00) return 8'h01;
    return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check8({tag, "_ledr"}, ledr, 8'h01);
    check8({tag, "_seg1"}, seg1, 8'b0000_0011);
    check8({tag, "_seg0"}, seg0, 8'b1001_1111);
    check8({tag, "_run"}, {7'd0, running}, 8'h00);
    check8({tag, "_cnt"}, step_cnt, 8'h00);
  endtask

  // Hold the given buttons, release, idle; tally LFSR changes and RUN sightings.
  task automatic press(input logic [2:0] b, input int hold, input int gap);
    logic [7:0] prev;
    nchg    = 0;
    saw_run = 1'b0;
    prev    = ledr;
    btn_step = b[0];
    btn_run  = b[1];
    btn_load = b[2];
    for (int i = 0; i < hold + gap; i++) begin
      if (i == hold) begin
        btn_step = 1'b0;
        btn_run  = 1'b0;
        btn_load = 1'b0;
      end
      @(negedge clk);
      if (ledr !== prev) nchg++;
      prev = ledr;
      if (running) saw_run = 1'b1;
    end
  endtask

  initial begin
    int         lat;
    int         bad;
    int         nshift;
    int         ecount;
    logic [7:0] old, exp_l;
    logic       run_at_80;

    vecs[0]  = '{3'b001, 8'h00, 8'h40, 8'h99, 8'h03, 2};
    vecs[1]  = '{3'b100, 8'hA5, 8'hA5, 8'h11, 8'h49, 0};
    vecs[2]  = '{3'b001, 8'h00, 8'h52, 8'h49, 8'h25, 1};
    vecs[3]  = '{3'b100, 8'h00, 8'h01, 8'h03, 8'h9F, 0};
    vecs[4]  = '{3'b001, 8'h00, 8'h80, 8'h01, 8'h03, 1};
    vecs[5]  = '{3'b100, 8'h3C, 8'h3C, 8'h0D, 8'h63, 0};
    vecs[6]  = '{3'b001, 8'h00, 8'h9E, 8'h09, 8'h61, 1};
    vecs[7]  = '{3'b001, 8'h00, 8'hCF, 8'h63, 8'h71, 2};
    vecs[8]  = '{3'b100, 8'hFF, 8'hFF, 8'h71, 8'h71, 0};
    vecs[9]  = '{3'b001, 8'h00, 8'h7F, 8'h1F, 8'h71, 1};
    vecs[10] = '{3'b100, 8'hBD, 8'hBD, 8'hC1, 8'h85, 0};
    vecs[11] = '{3'b001, 8'h00, 8'h5E, 8'h49, 8'h61, 1};
    vecs[12] = '{3'b100, 8'h67, 8'h67, 8'h41, 8'h1F, 0};

    rst_n = 1'b0; btn_step = 1'b0; btn_run = 1'b0; btn_load = 1'b0; sw = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_vals("reset");

    // First step: measure press-to-shift latency and the one-clock display lag.
    lat = 0;
    btn_step = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ledr !== 8'h01) begin lat = i; break; end
    end
    check_int("step_latency", lat, 20);
    check8("step1_ledr", ledr, 8'h80);
    check8("lag_seg1_old", seg1, 8'b0000_0011);
    check8("lag_seg0_old", seg0, 8'b1001_1111);
    @(negedge clk);
    check8("lag_seg1_new", seg1, 8'b0000_0001);
    check8("lag_seg0_new", seg0, 8'b0000_0011);
    repeat (8) @(negedge clk);
    btn_step = 1'b0;
    repeat (30) @(negedge clk);
    check8("step1_cnt", step_cnt, ecnt(1));

    // Table of single presses.
    for (int v = 0; v < 13; v++) begin
      sw = vecs[v].sw;
      press(vecs[v].btns, 30, 30);
      check8($sformatf("vec%0d_ledr", v), ledr, vecs[v].ledr);
      check8($sformatf("vec%0d_seg1", v), seg1, vecs[v].seg1);
      check8($sformatf("vec%0d_seg0", v), seg0, vecs[v].seg0);
      check8($sformatf("vec%0d_cnt", v), step_cnt, ecnt(vecs[v].cnt));
      check_int($sformatf("vec%0d_nchg", v), nchg, 1);
    end

    // Short glitch is filtered out.
    press(3'b001, 5, 40);
    check_int("glitch_nchg", nchg, 0);
    check8("glitch_ledr", ledr, 8'h67);

    // Long hold yields exactly one shift.
    press(3'b001, 200, 40);
    check_int("hold_nchg", nchg, 1);
    check8("hold_ledr", ledr, model_shift(8'h67));
    check8("hold_cnt", step_cnt, ecnt(1));

    // RUN: shift every 4th clock, step ignored, second run press stops it.
    old = ledr;
    lat = 0;
    btn_run = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (running) begin lat = i; break; end
    end
    check_int("run_latency", lat, 20);
    check8("run_entry_ledr", ledr, old);
    exp_l = old; bad = 0; nshift = 0; ecount = 1; run_at_80 = 1'b0;
    for (int j = 1; j <= 140; j++) begin
      @(negedge clk);
      if (running && (j % 4 == 0)) begin
        exp_l = model_shift(exp_l);
        nshift++;
        ecount++;
      end
      if (ledr !== exp_l) begin
        if (bad == 0) $display("FAIL run_seq j=%0d got=%02h exp=%02h", j, ledr, exp_l);
        bad++;
      end
      if (j == 80) run_at_80 = running;
      if (j == 5)   btn_run  = 1'b0;
      if (j == 10)  btn_step = 1'b1;
      if (j == 40)  btn_step = 1'b0;
      if (j == 70)  btn_run  = 1'b1;
      if (j == 100) btn_run  = 1'b0;
    end
    check_int("run_seq_errors", bad, 0);
    check_int("run_nshift", nshift, 22);
    check8("run_at_80", {7'd0, run_at_80}, 8'h01);
    check8("run_stopped", {7'd0, running}, 8'h00);
    check8("run_cnt", step_cnt, ecnt(ecount));

    // Load and step on the same cycle: load wins, no intermediate shift.
    sw = 8'h5A;
    press(3'b101, 30, 30);
    check_int("ld_step_nchg", nchg, 1);
    check8("ld_step_ledr", ledr, 8'h5A);
    check8("ld_step_cnt", step_cnt, 8'h00);

    // Load and run on the same cycle: load wins, RUN never entered.
    sw = 8'hC3;
    press(3'b110, 30, 30);
    check_int("ld_run_nchg", nchg, 1);
    check8("ld_run_saw_run", {7'd0, saw_run}, 8'h00);
    check8("ld_run_ledr", ledr, 8'hC3);

    // Reset in the middle of RUN.
    lat = 0;
    btn_run = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (running) begin lat = i; break; end
    end
    check_int("run2_latency", lat, 20);
    repeat (6) @(negedge clk);
    rst_n   = 1'b0;
    btn_run = 1'b0;
    @(negedge clk);
    check_reset_vals("midrun_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check8("post_rst_run", {7'd0, running}, 8'h00);
    check8("post_rst_ledr", ledr, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
